hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be exactly as listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 IF_ID_rs, IF_ID_rt  input  5 each  source register ids of the instruction in ID.
REQ-005 ID_uses_rs, ID_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-006 ID_is_branch  input  1  ID instruction is a conditional branch compared in ID.
REQ-007 branch_taken, jump  input  1 each  ID redirect resolved this cycle.
REQ-008 ID_EX_rd_out  input  5  final destination id (after RegDst mux) of instruction in EX.
REQ-009 ID_EX_reg_write_out, ID_EX_mem_read_out  input  1 each  EX instruction writes a register / is a load.
REQ-010 EX_MEM_rd_out  input  5; EX_MEM_mem_read_out  input  1  destination and load flag of instruction in MEM.
REQ-011 pc_write, IF_ID_write  output  1 each  1 = PC / IF_ID register may update.
REQ-012 ID_EX_bubble  output  1  1 = ID_EX loads all-zero control (nop).
REQ-013 IF_ID_flush  output  1  1 = IF_ID loads a nop.
REQ-014 stall_active  output  1  1 while in STALL state.
REQ-015 stall_cycles, flush_count  output  16 each  saturating event counters.

Function
REQ-016 A match SHALL require equal 5-bit ids, the relevant uses_* bit set, and destination id != 0.
REQ-017 Load-use hazard: ID_EX_mem_read_out and a match on ID_EX_rd_out -> 1 stall cycle.
REQ-018 Branch hazard, ID_is_branch only: ID_EX_mem_read_out match -> 2 stall cycles; ID_EX_reg_write_out (not load) match -> 1; EX_MEM_mem_read_out match on EX_MEM_rd_out -> 1; the largest applicable count SHALL win.
REQ-019 FSM states IDLE and STALL; a 2-bit remaining counter holds extra stall cycles.
REQ-020 In IDLE, detection SHALL be combinational: on hazard, same cycle pc_write=0, IF_ID_write=0, ID_EX_bubble=1; remaining <= count-1; go to STALL if count-1 > 0, else stay IDLE.
REQ-021 In STALL, stall outputs SHALL be asserted regardless of inputs; remaining decrements each cycle; transition to IDLE when it reaches 0 on that edge (STALL lasts exactly count-1 cycles).
REQ-022 Flush: in IDLE with no hazard, (branch_taken or jump) SHALL assert IF_ID_flush for that cycle only; pc_write and IF_ID_write stay 1.
REQ-023 Stall takes precedence: branch_taken/jump SHALL be ignored (no flush) in any cycle with stall outputs asserted.
REQ-024 stall_cycles SHALL increment by 1 every cycle stall outputs are asserted; flush_count by 1 every cycle IF_ID_flush=1; both saturate at 16'hFFFF.
REQ-025 With no hazard and no redirect: pc_write=1, IF_ID_write=1, ID_EX_bubble=0, IF_ID_flush=0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, remaining=0, counters=0, stall_active=0, regardless of clk.
REQ-027 Reset output values: pc_write=1, IF_ID_write=1, ID_EX_bubble=0, IF_ID_flush=0 (combinational outputs held at these during reset).
REQ-028 Reset asserted mid-stall SHALL abort the stall; the first cycle after release SHALL evaluate from IDLE.

Structure
REQ-029 State encodings, stall-count constants and counter width SHALL live in the shared constant_values.h header.
REQ-030 The saturating counter SHALL be one sub-module, sat_counter (16-bit, enable, async active-low reset), instantiated twice.

Verification
REQ-031 Load-use: EX lw rd=5, ID add rs=5 -> one cycle pc_write=0, ID_EX_bubble=1; next cycle free; stall_cycles=1.
REQ-032 Branch-on-load: EX lw rd=8, ID beq rs=8 -> exactly 2 stall cycles, stall_active=1 in second only; branch_taken asserted during stall -> no flush.
REQ-033 Branch-on-ALU: EX add rd=3 reg_write, ID beq rt=3 -> 1 stall; then branch_taken=1 -> IF_ID_flush one cycle, flush_count=1.
REQ-034 Zero register: EX lw rd=0, ID uses rs=0 -> no stall; uses_rs=0 with rs match -> no stall.
REQ-035 Reset mid-stall: rst_n low in STALL cycle -> immediate IDLE, pc_write=1, counters 0.
REQ-036 Saturation: force 65540 stall cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared constants for the hazard detection unit: FSM encoding, stall counts,
// counter width and the source/destination match rule.
package hazard_detection_unit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int CNT_W = 16;

  localparam logic [1:0] LOAD_USE_STALLS    = 2'd1;
  localparam logic [1:0] BR_LOAD_STALLS     = 2'd2;
  localparam logic [1:0] BR_ALU_STALLS      = 2'd1;
  localparam logic [1:0] BR_MEM_LOAD_STALLS = 2'd1;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic uses,
                                     input logic [4:0] dst);
    return uses && (src == dst) && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import hazard_detection_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard unit: stalls on load-use and ID-stage branch dependencies,
// flushes IF_ID on redirects, and counts stall / flush cycles.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_is_branch,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [4:0]       ID_EX_rd_out,
  input  logic             ID_EX_reg_write_out,
  input  logic             ID_EX_mem_read_out,
  input  logic [4:0]       EX_MEM_rd_out,
  input  logic             EX_MEM_mem_read_out,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_t     state;
  logic [1:0] remaining;
  logic [1:0] need;
  logic [1:0] need_minus_one;
  logic       ex_match;
  logic       mem_match;
  logic       stall;
  logic       flush;

  assign ex_match  = reg_match(IF_ID_rs, ID_uses_rs, ID_EX_rd_out) ||
                     reg_match(IF_ID_rt, ID_uses_rt, ID_EX_rd_out);
  assign mem_match = reg_match(IF_ID_rs, ID_uses_rs, EX_MEM_rd_out) ||
                     reg_match(IF_ID_rt, ID_uses_rt, EX_MEM_rd_out);

  // Total stall length demanded by the ID instruction; largest rule wins.
  always_comb begin
    need = 2'd0;
    if (ID_EX_mem_read_out && ex_match) need = LOAD_USE_STALLS;
    if (ID_is_branch) begin
      if (ID_EX_mem_read_out && ex_match) begin
        need = BR_LOAD_STALLS;
      end else if (ID_EX_reg_write_out && ex_match && (need < BR_ALU_STALLS)) begin
        need = BR_ALU_STALLS;
      end
      if (EX_MEM_mem_read_out && mem_match && (need < BR_MEM_LOAD_STALLS)) begin
        need = BR_MEM_LOAD_STALLS;
      end
    end
  end

  assign need_minus_one = need - 2'd1;

  // Outputs are forced to their idle values while reset is held.
  assign stall = rst_n && ((state == STALL) || (need != 2'd0));
  assign flush = rst_n && !stall && (branch_taken || jump);

  assign pc_write     = !stall;
  assign IF_ID_write  = !stall;
  assign ID_EX_bubble = stall;
  assign IF_ID_flush  = flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= 2'd0;
      stall_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (need != 2'd0) begin
            remaining <= need_minus_one;
            if (need_minus_one != 2'd0) begin
              state        <= STALL;
              stall_active <= 1'b1;
            end
          end
        end
        STALL: begin
          remaining <= remaining - 2'd1;
          if (remaining == 2'd1) begin
            state        <= IDLE;
            stall_active <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          remaining    <= 2'd0;
          stall_active <= 1'b0;
        end
      endcase
    end
  end

  sat_counter u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall),
    .count (stall_cycles)
  );

  sat_counter u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench: directed vector table, reset and saturation sequences,
// and randomized traffic against a cycle-count reference model.
module tb_hazard_detection_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  IF_ID_rs, IF_ID_rt;
  logic        ID_uses_rs, ID_uses_rt, ID_is_branch;
  logic        branch_taken, jump;
  logic [4:0]  ID_EX_rd_out;
  logic        ID_EX_reg_write_out, ID_EX_mem_read_out;
  logic [4:0]  EX_MEM_rd_out;
  logic        EX_MEM_mem_read_out;
  logic        pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, stall_active;
  logic [15:0] stall_cycles, flush_count;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_detection_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .IF_ID_rs            (IF_ID_rs),
    .IF_ID_rt            (IF_ID_rt),
    .ID_uses_rs          (ID_uses_rs),
    .ID_uses_rt          (ID_uses_rt),
    .ID_is_branch        (ID_is_branch),
    .branch_taken        (branch_taken),
    .jump                (jump),
    .ID_EX_rd_out        (ID_EX_rd_out),
    .ID_EX_reg_write_out (ID_EX_reg_write_out),
    .ID_EX_mem_read_out  (ID_EX_mem_read_out),
    .EX_MEM_rd_out       (EX_MEM_rd_out),
    .EX_MEM_mem_read_out (EX_MEM_mem_read_out),
    .pc_write            (pc_write),
    .IF_ID_write         (IF_ID_write),
    .ID_EX_bubble        (ID_EX_bubble),
    .IF_ID_flush         (IF_ID_flush),
    .stall_active        (stall_active),
    .stall_cycles        (stall_cycles),
    .flush_count         (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, br, taken, jmp;
    logic [4:0] ex_rd;
    logic       ex_rw, ex_ld;
    logic [4:0] mem_rd;
    logic       mem_ld;
    logic       e_pcw, e_bub, e_flush, e_sact;
    int         e_sc, e_fc;
  } vec_t;

  // Reference model: stall cycles still owed, plus the two event totals.
  int m_left, m_sc, m_fc;
  bit m_stall, m_flush, m_sact;

  function automatic bit dep(input logic [4:0] src, input logic uses, input logic [4:0] dst);
    return uses && (src == dst) && (dst != 0);
  endfunction

  function automatic int needed_stalls();
    int n = 0;
    bit exm  = dep(IF_ID_rs, ID_uses_rs, ID_EX_rd_out) || dep(IF_ID_rt, ID_uses_rt, ID_EX_rd_out);
    bit memm = dep(IF_ID_rs, ID_uses_rs, EX_MEM_rd_out) || dep(IF_ID_rt, ID_uses_rt, EX_MEM_rd_out);
    if (ID_EX_mem_read_out && exm) n = 1;
    if (ID_is_branch) begin
      if (ID_EX_mem_read_out && exm) n = (n > 2) ? n : 2;
      if (ID_EX_reg_write_out && !ID_EX_mem_read_out && exm) n = (n > 1) ? n : 1;
      if (EX_MEM_mem_read_out && memm) n = (n > 1) ? n : 1;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_left = 0; m_sc = 0; m_fc = 0;
  endtask

  // Expected outputs for the current inputs, before the coming edge.
  task automatic model_eval();
    int n = needed_stalls();
    m_sact  = (m_left > 0);
    m_stall = (m_left > 0) || (n > 0);
    m_flush = !m_stall && (branch_taken || jump);
  endtask

  task automatic model_advance();
    int n = needed_stalls();
    if (m_left > 0) m_left--;
    else if (n > 0) m_left = n - 1;
    if (m_stall) m_sc = (m_sc + 1 > 65535) ? 65535 : m_sc + 1;
    if (m_flush) m_fc = (m_fc + 1 > 65535) ? 65535 : m_fc + 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    IF_ID_rs = v.rs; IF_ID_rt = v.rt; ID_uses_rs = v.urs; ID_uses_rt = v.urt;
    ID_is_branch = v.br; branch_taken = v.taken; jump = v.jmp;
    ID_EX_rd_out = v.ex_rd; ID_EX_reg_write_out = v.ex_rw; ID_EX_mem_read_out = v.ex_ld;
    EX_MEM_rd_out = v.mem_rd; EX_MEM_mem_read_out = v.mem_ld;
  endtask

  task automatic idle_inputs();
    vec_t z = '{default: 0};
    drive(z);
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_model(input string tag);
    model_eval();
    check({tag, ".pc_write"},     int'(pc_write),     int'(!m_stall));
    check({tag, ".IF_ID_write"},  int'(IF_ID_write),  int'(!m_stall));
    check({tag, ".bubble"},       int'(ID_EX_bubble), int'(m_stall));
    check({tag, ".flush"},        int'(IF_ID_flush),  int'(m_flush));
    check({tag, ".stall_active"}, int'(stall_active), int'(m_sact));
    check({tag, ".stall_cycles"}, int'(stall_cycles), m_sc);
    check({tag, ".flush_count"},  int'(flush_count),  m_fc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input int rs, rt, urs, urt, br, tk, jp, exrd, exrw, exld,
                              memrd, memld, pcw, bub, fl, sa, sc, fc);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'(urs); v.urt = 1'(urt); v.br = 1'(br);
    v.taken = 1'(tk); v.jmp = 1'(jp); v.ex_rd = 5'(exrd); v.ex_rw = 1'(exrw);
    v.ex_ld = 1'(exld); v.mem_rd = 5'(memrd); v.mem_ld = 1'(memld);
    v.e_pcw = 1'(pcw); v.e_bub = 1'(bub); v.e_flush = 1'(fl); v.e_sact = 1'(sa);
    v.e_sc = sc; v.e_fc = fc;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    //              rs rt urs urt br tk jp exrd rw ld mrd mld | pcw bub fl sa  sc fc
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0)); // idle
    tbl.push_back(mk(5, 0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0)); // load-use
    tbl.push_back(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 1,   1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(8, 9, 1, 1, 1, 0, 0, 8, 1, 1, 0, 0,   0, 1, 0, 0, 1, 0)); // beq on lw
    tbl.push_back(mk(8, 9, 1, 1, 1, 1, 0, 0, 0, 0, 8, 1,   0, 1, 0, 1, 2, 0)); // taken ignored
    tbl.push_back(mk(8, 9, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 3, 0)); // flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 3, 1));
    tbl.push_back(mk(1, 3, 1, 1, 1, 0, 0, 3, 1, 0, 0, 0,   0, 1, 0, 0, 3, 1)); // beq on add
    tbl.push_back(mk(1, 3, 1, 1, 1, 1, 0, 0, 0, 0, 3, 0,   1, 0, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 4, 2)); // rd=0
    tbl.push_back(mk(5, 6, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0,   1, 0, 0, 0, 4, 2)); // uses_rs=0
    tbl.push_back(mk(7, 0, 1, 0, 1, 0, 1, 7, 1, 1, 0, 0,   0, 1, 0, 0, 4, 2)); // jump in stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 1, 5, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 6, 2));
    tbl.push_back(mk(4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 4, 1,   0, 1, 0, 0, 6, 2)); // beq on MEM lw
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 7, 2));

    // Outputs held at idle values during reset, even with a hazard present.
    #2;
    drive(tbl[1]);
    #1;
    check("rst.pc_write", int'(pc_write), 1);
    check("rst.bubble", int'(ID_EX_bubble), 0);
    check("rst.stall_cycles", int'(stall_cycles), 0);
    do_reset();

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d.pc_write", i), int'(pc_write), int'(tbl[i].e_pcw));
      check($sformatf("vec%0d.bubble", i), int'(ID_EX_bubble), int'(tbl[i].e_bub));
      check($sformatf("vec%0d.flush", i), int'(IF_ID_flush), int'(tbl[i].e_flush));
      check($sformatf("vec%0d.stall_active", i), int'(stall_active), int'(tbl[i].e_sact));
      check($sformatf("vec%0d.stall_cycles", i), int'(stall_cycles), tbl[i].e_sc);
      check($sformatf("vec%0d.flush_count", i), int'(flush_count), tbl[i].e_fc);
      $display("[TB] vec %0d pc_write=%0b bubble=%0b flush=%0b stall_active=%0b sc=%0d fc=%0d",
               i, pc_write, ID_EX_bubble, IF_ID_flush, stall_active, stall_cycles, flush_count);
    end

    // Reset asserted during the STALL cycle of a branch-on-load.
    do_reset();
    @(negedge clk);
    drive(tbl[3]);
    @(negedge clk);
    idle_inputs();
    #1;
    check("midrst.in_stall", int'(stall_active), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.pc_write", int'(pc_write), 1);
    check("midrst.stall_active", int'(stall_active), 0);
    check("midrst.stall_cycles", int'(stall_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("midrst.after_release", int'(pc_write), 1);
    $display("[TB] reset mid-stall pc_write=%0b stall_active=%0b sc=%0d",
             pc_write, stall_active, stall_cycles);

    // Randomized traffic with a narrow register range to provoke matches.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      vec_t v = '{default: 0};
      @(negedge clk);
      v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
      v.urs = 1'($urandom); v.urt = 1'($urandom); v.br = 1'($urandom);
      v.taken = 1'($urandom_range(0, 3) == 0); v.jmp = 1'($urandom_range(0, 5) == 0);
      v.ex_rd = 5'($urandom_range(0, 3)); v.ex_rw = 1'($urandom); v.ex_ld = 1'($urandom);
      v.mem_rd = 5'($urandom_range(0, 3)); v.mem_ld = 1'($urandom);
      drive(v);
      #1;
      check_model($sformatf("rnd%0d", c));
      @(posedge clk);
      model_advance();
    end
    $display("[TB] random phase done sc=%0d fc=%0d", stall_cycles, flush_count);

    // Saturation: hold a load-use hazard for 65540 cycles.
    do_reset();
    @(negedge clk);
    drive(tbl[1]);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    #1;
    check("sat.stall_cycles", int'(stall_cycles), 65535);
    check("sat.flush_count", int'(flush_count), 0);
    $display("[TB] saturation stall_cycles=%0h", stall_cycles);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
